// File: rtl/mux2x4_rr_arbiter_pkg.sv
// Shared definitions for the two-source round-robin arbiter in front of the 2:1 x4 mux.
package mux2x4_rr_arbiter_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/mux2x4_rr_arbiter_mux.sv
// Mux2x4 cell generalised to WIDTH: O follows I0 when S is low, I1 when S is high.
module Mux2x4 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             S,
    output logic [WIDTH-1:0] O
);

    // Pure select, no state.
    always_comb begin
        if (S) begin
            O = I1;
        end else begin
            O = I0;
        end
    end

endmodule

// File: rtl/mux2x4_rr_arbiter_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping back to zero.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: bump only on inc and only while below the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mux2x4_rr_arbiter.sv
// Round-robin arbiter between two valid/ready producers, driving the mux select
// and a one-entry output register with its own valid/ready handshake.
module mux2x4_rr_arbiter
    import mux2x4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] I0,
    input  logic             I0_valid,
    output logic             I0_ready,
    input  logic [WIDTH-1:0] I1,
    input  logic             I1_valid,
    output logic             I1_ready,
    output logic [WIDTH-1:0] O,
    output logic             O_valid,
    input  logic             O_ready,
    output logic             last_grant,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic             load_s;
    logic             sel_s;
    logic             xfer_s;
    logic [WIDTH-1:0] mux_out_s;

    logic [WIDTH-1:0] o_d;
    logic [WIDTH-1:0] o_q;
    logic             o_valid_d;
    logic             o_valid_q;
    logic             last_grant_d;
    logic             last_grant_q;

    // Slot can take a word when empty or when it is being drained this cycle.
    assign load_s = ~o_valid_q | O_ready;

    // Round-robin select; idle cycles hold the previous grant so S does not toggle.
    always_comb begin
        sel_s = last_grant_q;
        case ({I1_valid, I0_valid})
            2'b01:   sel_s = SRC0;
            2'b10:   sel_s = SRC1;
            2'b11:   sel_s = ~last_grant_q;
            default: sel_s = last_grant_q;
        endcase
    end

    // Readys are held low while reset is asserted even though the slot looks free.
    assign I0_ready = ~ASYNCRESET & load_s & I0_valid & (sel_s == SRC0);
    assign I1_ready = ~ASYNCRESET & load_s & I1_valid & (sel_s == SRC1);
    assign xfer_s   = I0_ready | I1_ready;

    Mux2x4 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .I0 (I0),
        .I1 (I1),
        .S  (sel_s),
        .O  (mux_out_s)
    );

    // Output slot next state: refill wins over drain so throughput stays one word per cycle.
    always_comb begin
        o_d          = o_q;
        o_valid_d    = o_valid_q;
        last_grant_d = last_grant_q;
        if (xfer_s) begin
            o_d          = mux_out_s;
            o_valid_d    = 1'b1;
            last_grant_d = sel_s;
        end else if (O_ready) begin
            o_valid_d    = 1'b0;
        end else begin
            o_valid_d    = o_valid_q;
        end
    end

    // Output slot and arbitration state; last_grant resets to SRC1 so SRC0 wins the first tie.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            o_q          <= {WIDTH{1'b0}};
            o_valid_q    <= 1'b0;
            last_grant_q <= SRC1;
        end else begin
            o_q          <= o_d;
            o_valid_q    <= o_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt0 (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .inc        (I0_ready),
        .count      (cnt0)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt1 (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .inc        (I1_ready),
        .count      (cnt1)
    );

    assign O          = o_q;
    assign O_valid    = o_valid_q;
    assign last_grant = last_grant_q;

endmodule
